// File: rtl/sha256_round_engine.sv
// SHA-256 compression core: 64 rounds over a..h fed by an external W/K stream,
// then folds the working variables into the chaining state H0..H7.
module sha256_round_engine #(
    parameter int           ROUNDS = 64,
    parameter logic [255:0] IV     = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         first_blk,
    input  logic [31:0]  w_in,
    input  logic [31:0]  k_in,
    input  logic         w_valid,
    output logic [5:0]   rnd_idx,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

    state_t      state_reg, state_next;
    logic [31:0] wv_reg [8];   // working variables a..h at indices 0..7
    logic [31:0] wv_next [8];
    logic [31:0] h_reg [8];
    logic [31:0] h_next [8];
    logic [5:0]  rnd_reg, rnd_next;
    logic        done_reg, done_next;

    logic [31:0] iv_w [8];
    logic [31:0] h_sum [8];
    logic [31:0] big_s0, big_s1, ch, maj, t1, t2;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_words
            assign iv_w[gi]                  = IV[255 - 32*gi -: 32];
            assign h_sum[gi]                 = h_reg[gi] + wv_reg[gi];
            assign digest[255 - 32*gi -: 32] = h_reg[gi];
        end
    endgenerate

    assign big_s0 = rotr(wv_reg[0], 2) ^ rotr(wv_reg[0], 13) ^ rotr(wv_reg[0], 22);
    assign big_s1 = rotr(wv_reg[4], 6) ^ rotr(wv_reg[4], 11) ^ rotr(wv_reg[4], 25);
    assign ch     = (wv_reg[4] & wv_reg[5]) ^ (~wv_reg[4] & wv_reg[6]);
    assign maj    = (wv_reg[0] & wv_reg[1]) ^ (wv_reg[0] & wv_reg[2]) ^ (wv_reg[1] & wv_reg[2]);
    assign t1     = wv_reg[7] + big_s1 + ch + k_in + w_in;
    assign t2     = big_s0 + maj;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            rnd_reg   <= '0;
            done_reg  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                wv_reg[i] <= '0;
                h_reg[i]  <= IV[255 - 32*i -: 32];
            end
        end else begin
            state_reg <= state_next;
            rnd_reg   <= rnd_next;
            done_reg  <= done_next;
            for (int i = 0; i < 8; i++) begin
                wv_reg[i] <= wv_next[i];
                h_reg[i]  <= h_next[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        rnd_next   = rnd_reg;
        done_next  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wv_next[i] = wv_reg[i];
            h_next[i]  = h_reg[i];
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 8; i++) begin
                        if (first_blk) begin
                            h_next[i]  = iv_w[i];
                            wv_next[i] = iv_w[i];
                        end else begin
                            wv_next[i] = h_reg[i];
                        end
                    end
                    rnd_next   = '0;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                if (w_valid) begin
                    for (int i = 1; i < 8; i++) begin
                        wv_next[i] = wv_reg[i-1];
                    end
                    wv_next[4] = wv_reg[3] + t1;
                    wv_next[0] = t1 + t2;
                    if (rnd_reg == LAST_RND) begin
                        rnd_next   = '0;
                        state_next = FINAL;
                    end else begin
                        rnd_next = rnd_reg + 6'd1;
                    end
                end
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    h_next[i] = h_sum[i];
                end
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rnd_idx = rnd_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine: drives known padded blocks through a
// local message schedule and compares digests, latency and control outputs.
module tb_sha256_round_engine;

    localparam logic [255:0] IV_VAL  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         first_blk;
    logic [31:0]  w_in;
    logic [31:0]  k_in;
    logic         w_valid;
    logic [5:0]   rnd_idx;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    int checks = 0;
    int errors = 0;

    logic [31:0]  k_tab [64];
    logic [31:0]  w_sched [64];
    logic [511:0] blk_abc, blk_empty, blk_two_1, blk_two_2;

    sha256_round_engine dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .first_blk (first_blk),
        .w_in      (w_in),
        .k_in      (k_in),
        .w_valid   (w_valid),
        .rnd_idx   (rnd_idx),
        .busy      (busy),
        .done      (done),
        .digest    (digest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic load_block(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) w_sched[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w_sched[i] = (rotr(w_sched[i-2], 17) ^ rotr(w_sched[i-2], 19) ^ (w_sched[i-2] >> 10))
                       + w_sched[i-7]
                       + (rotr(w_sched[i-15], 7) ^ rotr(w_sched[i-15], 18) ^ (w_sched[i-15] >> 3))
                       + w_sched[i-16];
    endtask

    // Entered and left on a falling edge; on return the DUT is in its done cycle.
    task automatic run_block(input string name, input logic first, input int stall_pct, input bit pulse);
        int t, edges, stalls, busy_cyc;
        t = 0; edges = 0; stalls = 0; busy_cyc = 0;
        start = 1'b1; first_blk = first; w_valid = 1'b0;
        @(posedge clk);
        while (t < 64) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            check({name, " rnd_idx"}, 256'(rnd_idx), 256'(t));
            start     = pulse && (t == 10 || t == 63);
            first_blk = 1'b1;
            w_valid   = ($urandom_range(99) >= stall_pct);
            w_in      = w_sched[t];
            k_in      = k_tab[t];
            @(posedge clk);
            edges++;
            if (w_valid) t++; else stalls++;
        end
        @(negedge clk);
        if (busy) busy_cyc++;
        check({name, " done_early"}, 256'(done), 256'(0));
        w_valid = 1'b0; start = 1'b0;
        @(posedge clk);
        edges++;
        @(negedge clk);
        check({name, " done"}, 256'(done), 256'(1));
        check({name, " busy_end"}, 256'(busy), 256'(0));
        check({name, " latency"}, 256'(edges), 256'(65 + stalls));
        check({name, " busy_cycles"}, 256'(busy_cyc), 256'(65 + stalls));
        $display("block %s first=%0d stalls=%0d edges=%0d digest=%h", name, first, stalls, edges, digest);
    endtask

    initial begin
        k_tab = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };
        blk_abc   = {32'h61626380, 448'h0, 32'h00000018};
        blk_empty = {32'h80000000, 480'h0};
        blk_two_1 = {448'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071,
                     32'h80000000, 32'h00000000};
        blk_two_2 = {480'h0, 32'h000001c0};

        reset_n = 1'b0; start = 1'b0; first_blk = 1'b0;
        w_in = '0; k_in = '0; w_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst digest", digest, IV_VAL);
        check("rst busy", 256'(busy), 256'(0));
        check("rst done", 256'(done), 256'(0));
        check("rst rnd_idx", 256'(rnd_idx), 256'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Test 1: "abc", no stalls
        load_block(blk_abc);
        run_block("abc", 1'b1, 0, 1'b0);
        check("abc digest", digest, D_ABC);
        @(negedge clk);
        check("abc done_pulse", 256'(done), 256'(0));
        check("abc digest_hold", digest, D_ABC);

        // Test 2: empty message
        load_block(blk_empty);
        run_block("empty", 1'b1, 0, 1'b0);
        check("empty digest", digest, D_EMPTY);
        @(negedge clk);

        // Test 3: two blocks, second started in the done cycle of the first
        load_block(blk_two_1);
        run_block("two_1", 1'b1, 0, 1'b0);
        load_block(blk_two_2);
        run_block("two_2", 1'b0, 0, 1'b0);
        check("two digest", digest, D_TWO);
        @(negedge clk);

        // Test 4: "abc" with ~40% stalls
        load_block(blk_abc);
        run_block("abc_stall", 1'b1, 40, 1'b0);
        check("abc_stall digest", digest, D_ABC);
        @(negedge clk);

        // Test 5a: start pulses mid-block are ignored
        load_block(blk_abc);
        run_block("abc_pulse", 1'b1, 0, 1'b1);
        check("abc_pulse digest", digest, D_ABC);
        @(negedge clk);

        // Test 5b: reset at round 30 of a continuation block
        start = 1'b1; first_blk = 1'b0;
        @(posedge clk);
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            start = 1'b0; w_valid = 1'b1;
            w_in = w_sched[t]; k_in = k_tab[t];
        end
        @(negedge clk);
        check("abort pre rnd_idx", 256'(rnd_idx), 256'(30));
        reset_n = 1'b0;
        #1;
        check("abort busy", 256'(busy), 256'(0));
        check("abort done", 256'(done), 256'(0));
        check("abort rnd_idx", 256'(rnd_idx), 256'(0));
        check("abort digest", digest, IV_VAL);
        $display("abort at round 30 digest=%h", digest);
        w_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Test 5c: full run after abort
        run_block("abc_after", 1'b1, 0, 1'b0);
        check("abc_after digest", digest, D_ABC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
